// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// FETCH_ALIGN_CHECK_EN enables branch-target misalignment reporting.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_t;

  localparam int INSTR_BYTES = 4;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ifetch_pc.sv
// Program counter with sequential incrementer and branch-target adder.
// FETCH_ALIGN_CHECK_EN exposes whether the raw target had low bits set.
module ifetch_pc
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        sel,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  output logic [31:0] pc,
  output logic        tgt_bad
);

  localparam logic [31:0] STEP = 32'(INSTR_BYTES);

  logic [31:0] target;
  logic [31:0] next_pc;

  assign target  = base + STEP + offset;
  assign next_pc = sel ? (target & ~32'd3)
                       : pc + STEP;

`ifdef FETCH_ALIGN_CHECK_EN
  assign tgt_bad = |target[1:0];
`else
  assign tgt_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset)
      pc <= RESET_PC;
    else if (load)
      pc <= next_pc;
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: imem req/ack in, decode valid/ready out.
// FETCH_ALIGN_CHECK_EN enables the misalign pulse on branches.
module ifetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        pc_branch,
  input  logic [31:0] branch_immed,
  output logic        misalign
);

  state_t      state;
  logic [31:0] pc;
  logic        pc_load;
  logic        pc_sel;
  logic        tgt_bad;
  logic        hs;

  assign hs        = instr_valid & instr_ready;
  assign imem_addr = pc;

  // pc already advanced by 4 at capture, so only a branch reloads it
  always_comb begin
    pc_load = 1'b0;
    pc_sel  = 1'b0;
    unique case (1'b1)
      state == FETCH: pc_load = imem_ack;
      state == HOLD: begin
        pc_sel  = 1'b1;
        pc_load = hs & pc_branch;
      end
      default: ;
    endcase
  end

  ifetch_pc #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk    (clk),
    .reset  (reset),
    .load   (pc_load),
    .sel    (pc_sel),
    .base   (instr_pc),
    .offset (branch_immed),
    .pc     (pc),
    .tgt_bad(tgt_bad)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      imem_req    <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      misalign <= 1'b0;
      unique case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (hs) begin
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            misalign    <= pc_branch & tgt_bad;
            state       <= FETCH;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch against a transaction-level PC model.
// Honours FETCH_ALIGN_CHECK_EN for the expected misalign pulse.
module tb_ifetch;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        pc_branch = 1'b0;
  logic [31:0] branch_immed = '0;
  logic        misalign;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ifetch dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_branch   (pc_branch),
    .branch_immed(branch_immed),
    .misalign    (misalign)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic fetch_now(input logic [31:0] d);
    imem_ack  = 1'b1;
    imem_data = d;
    tick();
    imem_ack  = 1'b0;
    imem_data = $urandom;
  endtask

  task automatic consume(input logic br, input logic [31:0] imm);
    instr_ready  = 1'b1;
    pc_branch    = br;
    branch_immed = imm;
    tick();
    instr_ready  = 1'b0;
    pc_branch    = 1'b0;
    branch_immed = $urandom;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    imem_ack = 1'b1;
    repeat (3) tick();
    imem_ack = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr got=%h exp=0", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_ipc got=%h exp=0", instr_pc); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL rst_mis got=%b exp=0", misalign); end
    reset = 1'b1;
  endtask

  task automatic test_same_cycle_ack();
    tick();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL sc_req got=%b exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL sc_addr got=%h exp=0", imem_addr); end
    fetch_now(32'h1111_1111);
    checks++; if (instr !== 32'h1111_1111) begin errors++; $display("FAIL sc_instr got=%h exp=11111111", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL sc_ipc got=%h exp=0", instr_pc); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL sc_valid got=%b exp=1", instr_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL sc_req_off got=%b exp=0", imem_req); end
    consume(1'b0, 32'h0);
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL sc_next got=%h exp=4", imem_addr); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL sc_req2 got=%b exp=1", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL sc_valid2 got=%b exp=0", instr_valid); end
  endtask

  task automatic test_delayed_ack();
    for (int i = 0; i < 4; i++) begin
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL dly_req[%0d] got=%b exp=1", i, imem_req); end
      checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL dly_addr[%0d] got=%h exp=4", i, imem_addr); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL dly_valid[%0d] got=%b exp=0", i, instr_valid); end
      if (i == 3) fetch_now(mem_word(32'h4));
      else tick();
    end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL dly_rise got=%b exp=1", instr_valid); end
    checks++; if (instr !== mem_word(32'h4)) begin errors++; $display("FAIL dly_instr got=%h exp=%h", instr, mem_word(32'h4)); end
    checks++; if (instr_pc !== 32'h4) begin errors++; $display("FAIL dly_ipc got=%h exp=4", instr_pc); end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      pc_branch    = 1'b1;
      branch_immed = $urandom;
      tick();
      checks++; if (instr !== mem_word(32'h4)) begin errors++; $display("FAIL hold_instr[%0d] got=%h exp=%h", i, instr, mem_word(32'h4)); end
      checks++; if (instr_pc !== 32'h4) begin errors++; $display("FAIL hold_ipc[%0d] got=%h exp=4", i, instr_pc); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req[%0d] got=%b exp=0", i, imem_req); end
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got=%b exp=1", i, instr_valid); end
    end
    consume(1'b0, $urandom);
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL hold_next got=%h exp=8", imem_addr); end
  endtask

  task automatic test_branch();
    fetch_now(mem_word(32'h8));
    consume(1'b1, 32'h0000_00F4);
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL br_to100 got=%h exp=100", imem_addr); end
    fetch_now(mem_word(32'h100));
    consume(1'b1, 32'hFFFF_FFF0);
    checks++; if (imem_addr !== 32'hF4) begin errors++; $display("FAIL br_back got=%h exp=f4", imem_addr); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL br_back_mis got=%b exp=0", misalign); end
    fetch_now(mem_word(32'hF4));
    consume(1'b1, 32'h8);
    fetch_now(mem_word(32'h100));
    consume(1'b1, 32'h6);
    checks++; if (imem_addr !== 32'h108) begin errors++; $display("FAIL br_odd got=%h exp=108", imem_addr); end
    checks++; if (misalign !== ALIGN) begin errors++; $display("FAIL br_mis got=%b exp=%b", misalign, ALIGN); end
    tick();
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL br_mis_end got=%b exp=0", misalign); end
    checks++; if (imem_addr !== 32'h108) begin errors++; $display("FAIL br_addr_hold got=%h exp=108", imem_addr); end
  endtask

  task automatic test_reset_mid();
    reset     = 1'b0;
    imem_ack  = 1'b0;
    tick();
    imem_ack  = 1'b1;
    imem_data = 32'hDEAD_BEEF;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rm_req got=%b exp=0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rm_addr got=%h exp=0", imem_addr); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rm_instr got=%h exp=0", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rm_ipc got=%h exp=0", instr_pc); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got=%b exp=0", instr_valid); end
    reset = 1'b1;
    tick();
    imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rm_late_ack got=%b exp=0", instr_valid); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rm_restart got=%b exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rm_raddr got=%h exp=0", imem_addr); end
  endtask

  task automatic test_wrap();
    fetch_now(mem_word(32'h0));
    consume(1'b1, 32'hFFFF_FFF8);
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top got=%h exp=fffffffc", imem_addr); end
    fetch_now(mem_word(32'hFFFF_FFFC));
    checks++; if (instr_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_ipc got=%h exp=fffffffc", instr_pc); end
    consume(1'b0, 32'h0);
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_zero got=%h exp=0", imem_addr); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] imm;
    logic [31:0] tgt;
    logic [31:0] nxt;
    logic        br;
    logic        exp_mis;
    int          dly;
    int          rdy;
    exp_pc = 32'h0;
    for (int t = 0; t < 150; t++) begin
      dly = int'($urandom_range(0, 3));
      for (int k = 0; k <= dly; k++) begin
        checks++; if (imem_addr !== exp_pc || imem_req !== 1'b1) begin errors++; $display("FAIL rnd_req[%0d] addr=%h req=%b exp=%h/1", t, imem_addr, imem_req, exp_pc); end
        if (k == dly) fetch_now(mem_word(exp_pc));
        else tick();
      end
      checks++; if (instr_valid !== 1'b1 || instr !== mem_word(exp_pc)) begin errors++; $display("FAIL rnd_instr[%0d] got=%h v=%b exp=%h", t, instr, instr_valid, mem_word(exp_pc)); end
      checks++; if (instr_pc !== exp_pc) begin errors++; $display("FAIL rnd_ipc[%0d] got=%h exp=%h", t, instr_pc, exp_pc); end
      rdy = int'($urandom_range(0, 3));
      for (int k = 0; k < rdy; k++) begin
        pc_branch    = 1'($urandom);
        branch_immed = $urandom;
        tick();
        checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr_pc !== exp_pc) begin errors++; $display("FAIL rnd_hold[%0d] v=%b req=%b ipc=%h exp=1/0/%h", t, instr_valid, imem_req, instr_pc, exp_pc); end
      end
      br  = 1'($urandom);
      imm = 32'(int'($urandom_range(0, 511)) - 256);
      if (($urandom % 8) == 0) imm = $urandom;
      tgt     = exp_pc + 32'd4 + imm;
      exp_mis = br && ALIGN && (tgt % 4 != 0);
      nxt     = br ? tgt - (tgt % 4) : exp_pc + 32'd4;
      consume(br, imm);
      checks++; if (imem_addr !== nxt) begin errors++; $display("FAIL rnd_next[%0d] got=%h exp=%h", t, imem_addr, nxt); end
      checks++; if (misalign !== exp_mis) begin errors++; $display("FAIL rnd_mis[%0d] got=%b exp=%b", t, misalign, exp_mis); end
      exp_pc = nxt;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_same_cycle_ack();
    test_delayed_ack();
    test_hold();
    test_branch();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
